// File: rtl/vec_assembler_pkg.sv
// Shared sizing for the chunked fetch -> assembler -> reduction-tree path.
// Element type and the default vector and chunk geometry.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 8
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

package vec_assembler_pkg;
  localparam int VEC_LEN_DEF    = `MAX_EMBEDDING_DIM;
  localparam int CHUNK_LEN_DEF  = 4;
  localparam int W_DEF          = 2 * `INTEGER_WIDTH;
  localparam int CHUNKS_PER_VEC = VEC_LEN_DEF / CHUNK_LEN_DEF;

  typedef logic signed [W_DEF-1:0] elem_t;
endpackage

// File: rtl/vec_assembler.sv
// Collects CHUNK_LEN-element beats into one VEC_LEN-element vector. One vector
// can be under construction while a finished one waits in the output register.
module vec_assembler
  import vec_assembler_pkg::*;
#(
  parameter int VEC_LEN    = VEC_LEN_DEF,
  parameter int CHUNK_LEN  = CHUNK_LEN_DEF,
  parameter int W          = W_DEF,
  parameter int NUM_CHUNKS = VEC_LEN / CHUNK_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_in,
  output logic                rdy_out,
  input  logic signed [W-1:0] chunk_in [CHUNK_LEN],
  input  logic                last_in,
  output logic                vld_out,
  input  logic                rdy_in,
  output logic signed [W-1:0] vec_out [VEC_LEN]
);
  localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef logic signed [W-1:0] el_t;

  el_t           fill_q [VEC_LEN];
  el_t           fill_d [VEC_LEN];
  el_t           out_q  [VEC_LEN];
  el_t           out_d  [VEC_LEN];
  el_t           merged [VEC_LEN];
  logic [IW-1:0] idx_q, idx_d;
  logic          pend_q, pend_d;
  logic          oval_q, oval_d;
  logic          acc, slot_free, done;

  assign rdy_out   = !pend_q;
  assign vld_out   = oval_q;
  assign vec_out   = out_q;
  assign acc       = vld_in && !pend_q;
  assign slot_free = !oval_q || rdy_in;
  assign done      = acc && (last_in || idx_q == IW'(NUM_CHUNKS - 1));

  // fill_buf is zeroed whenever it hands off, so unwritten slots read as 0.
  always_comb begin
    merged = fill_q;
    for (int c = 0; c < NUM_CHUNKS; c++)
      if (idx_q == IW'(c))
        for (int k = 0; k < CHUNK_LEN; k++)
          merged[c*CHUNK_LEN + k] = chunk_in[k];
  end

  always_comb begin
    fill_d = fill_q;
    out_d  = out_q;
    idx_d  = idx_q;
    pend_d = pend_q;
    oval_d = oval_q;
    if (oval_q && rdy_in) oval_d = 1'b0;
    if (pend_q && slot_free) begin
      out_d  = fill_q;
      oval_d = 1'b1;
      pend_d = 1'b0;
      fill_d = '{default: '0};
    end else if (acc) begin
      if (done) begin
        idx_d = '0;
        if (slot_free) begin
          out_d  = merged;
          oval_d = 1'b1;
          fill_d = '{default: '0};
        end else begin
          fill_d = merged;
          pend_d = 1'b1;
        end
      end else begin
        fill_d = merged;
        idx_d  = IW'(idx_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '{default: '0};
      out_q  <= '{default: '0};
      idx_q  <= '0;
      pend_q <= 1'b0;
      oval_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      out_q  <= out_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      oval_q <= oval_d;
    end
  end
endmodule

// File: tb/tb_vec_assembler.sv
// Self-checking bench for vec_assembler: directed table, corner sequences and
// randomized traffic against a queue-based model of emitted vectors.
module tb_vec_assembler;
  localparam int VL = 8;
  localparam int CL = 2;
  localparam int W  = 16;
  localparam int NC = VL / CL;

  typedef logic signed [W-1:0] el_t;
  typedef logic [VL*W-1:0]     pvec_t;
  typedef struct {
    int  nb;
    el_t d   [VL];
    el_t exp [VL];
  } rec_t;

  logic clk = 0, rst = 1, vld_in = 0, last_in = 0, rdy_in = 1;
  logic rdy_out, vld_out;
  el_t  chunk_in [CL];
  el_t  vec_out  [VL];

  vec_assembler #(.VEC_LEN(VL), .CHUNK_LEN(CL), .W(W)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
    .chunk_in(chunk_in), .last_in(last_in), .vld_out(vld_out),
    .rdy_in(rdy_in), .vec_out(vec_out)
  );

  always #5 clk = ~clk;

  int    nchk = 0, nerr = 0, npush = 0, npop = 0;
  pvec_t expq [$];
  el_t   cur [VL];
  int    bi = 0;
  rec_t  tbl [4];
  logic  rnd_done;

  function automatic pvec_t pack(input el_t v [VL]);
    pvec_t p;
    for (int i = 0; i < VL; i++) p[i*W +: W] = v[i];
    return p;
  endfunction

  task automatic chk(input string nm, input pvec_t act, input pvec_t exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: a beat lands at the bench's own beat index; a vector is done on
  // last or when all NC beats are in, and unwritten elements stay zero.
  task automatic model_beat(input el_t a, input el_t b, input logic last);
    cur[bi*CL]     = a;
    cur[bi*CL + 1] = b;
    if (last || bi == NC - 1) begin
      expq.push_back(pack(cur));
      npush++;
      cur = '{default: '0};
      bi  = 0;
    end else bi++;
  endtask

  task automatic model_reset();
    cur = '{default: '0};
    bi  = 0;
    expq.delete();
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input el_t a, input el_t b, input logic last);
    logic acc = 0;
    int   n = 0;
    vld_in = 1; chunk_in[0] = a; chunk_in[1] = b; last_in = last;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (rdy_out) begin
        acc = 1;
        model_beat(a, b, last);
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("beat_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    vld_in = 0; last_in = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Every emission is checked against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && vld_out && rdy_in) begin
      npop++;
      if (expq.size() == 0) chk("emit_unexpected", pack(vec_out), 0);
      else chk("emit_data", pack(vec_out), expq.pop_front());
    end
  end

  initial begin
    cur = '{default: '0};
    chunk_in = '{default: '0};
    tbl[0].nb = 4; tbl[0].d = '{1, 2, 3, 4, 5, 6, 7, 8};
    tbl[0].exp = '{1, 2, 3, 4, 5, 6, 7, 8};
    tbl[1].nb = 2; tbl[1].d = '{-1, -2, 3, 4, 9, 9, 9, 9};
    tbl[1].exp = '{-1, -2, 3, 4, 0, 0, 0, 0};
    tbl[2].nb = 1; tbl[2].d = '{5, -6, 9, 9, 9, 9, 9, 9};
    tbl[2].exp = '{5, -6, 0, 0, 0, 0, 0, 0};
    tbl[3].nb = 4; tbl[3].d = '{32767, -32768, -1, 0, 100, -100, 1, 2};
    tbl[3].exp = '{32767, -32768, -1, 0, 100, -100, 1, 2};

    // reset
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_vld_out", vld_out, 0);
    chk("rst_rdy_out", rdy_out, 1);
    chk("rst_vec_out", pack(vec_out), 0);

    // table: one-cycle pulse the cycle after the completing accept
    rdy_in = 1;
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < tbl[t].nb; b++)
        send_beat(tbl[t].d[2*b], tbl[t].d[2*b+1], b == tbl[t].nb - 1);
      vld_in = 0; last_in = 0;
      chk($sformatf("tbl%0d_vld", t), vld_out, 1);
      chk($sformatf("tbl%0d_vec", t), pack(vec_out), pack(tbl[t].exp));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_pulse_end", t), vld_out, 0);
    end

    // backpressure: A held in output, B pending, third vector stalls
    rdy_in = 0;
    for (int b = 0; b < NC; b++) send_beat(el_t'(2*b+1), el_t'(2*b+2), b == NC-1);
    for (int b = 0; b < NC; b++) send_beat(el_t'(2*b+11), el_t'(2*b+12), b == NC-1);
    chk("bp_rdy_low", rdy_out, 0);
    vld_in = 1; chunk_in[0] = 21; chunk_in[1] = 22; last_in = 0;
    repeat (3) begin
      @(negedge clk); chk("bp_hold_rdy", rdy_out, 0);
      @(posedge clk); #1;
    end
    rdy_in = 1;
    @(negedge clk);
    chk("bp_A_vld", vld_out, 1);
    chk("bp_A_vec", pack(vec_out), pack('{1, 2, 3, 4, 5, 6, 7, 8}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_B_vec", pack(vec_out), pack('{11, 12, 13, 14, 15, 16, 17, 18}));
    chk("bp_rdy_back", rdy_out, 1);
    model_beat(21, 22, 0);
    @(posedge clk); #1;
    for (int b = 1; b < NC; b++) send_beat(el_t'(2*b+21), el_t'(2*b+22), b == NC-1);
    vld_in = 0;
    chk("bp_C_vec", pack(vec_out), pack('{21, 22, 23, 24, 25, 26, 27, 28}));
    idle(2);

    // reset mid-fill discards the partial vector
    send_beat(9, 9, 0);
    send_beat(9, 9, 0);
    vld_in = 0;
    rst = 1; model_reset();
    @(posedge clk); #1 rst = 0;
    chk("midrst_vld", vld_out, 0);
    for (int b = 0; b < NC; b++) send_beat(el_t'(2*b+1), el_t'(2*b+2), b == NC-1);
    vld_in = 0;
    chk("midrst_vec", pack(vec_out), pack('{1, 2, 3, 4, 5, 6, 7, 8}));
    idle(2);

    // drain of A on the same edge B completes: no bubble
    rdy_in = 0;
    for (int b = 0; b < NC; b++) send_beat(el_t'(2*b+31), el_t'(2*b+32), b == NC-1);
    for (int b = 0; b < NC-1; b++) send_beat(el_t'(2*b+41), el_t'(2*b+42), 0);
    rdy_in = 1;
    send_beat(47, 48, 1);
    vld_in = 0;
    chk("coll_vld", vld_out, 1);
    chk("coll_vec", pack(vec_out), pack('{41, 42, 43, 44, 45, 46, 47, 48}));
    @(posedge clk); #1;
    chk("coll_drained", vld_out, 0);
    idle(2);

    // randomized traffic with random backpressure
    rnd_done = 0;
    fork
      begin
        for (int v = 0; v < 60; v++) begin
          int nb = ($urandom_range(0, 1) != 0) ? NC : $urandom_range(1, NC);
          for (int b = 0; b < nb; b++) begin
            send_beat(el_t'($urandom), el_t'($urandom), (b == nb-1) && (nb < NC || $urandom_range(0,1) != 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          end
        end
        vld_in = 0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          rdy_in = ($urandom_range(0, 3) != 0);
        end
        rdy_in = 1;
      end
    join
    for (int n = 0; n < 100 && expq.size() != 0; n++) begin @(posedge clk); #1; end
    chk("final_queue_empty", expq.size(), 0);
    chk("final_emit_count", npop, npush);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/vec_assembler.md
Name: vec_assembler

Overview:
Deserializer that collects a stream of narrow CHUNK_LEN-element beats into one full VEC_LEN-element vector. It presents that vector to reduction-tree stages over the same vld/rdy handshake they use. It sits upstream of the summation pipeline, between the chunked SRAM/operand fetch and the first reduction stage. It holds one vector under construction plus one completed vector, so a fill and a drain can overlap.

Parameters:
VEC_LEN, `MAX_EMBEDDING_DIM, elements per assembled vector
CHUNK_LEN, 4, elements per input beat; must divide VEC_LEN
W, 2*`INTEGER_WIDTH, signed element width
NUM_CHUNKS, VEC_LEN/CHUNK_LEN, beats per full vector (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
vld_in  in  1  upstream beat valid
rdy_out  out  1  this block can accept a beat
chunk_in  in  W x CHUNK_LEN (signed unpacked)  beat payload
last_in  in  1  beat is the final beat of the current vector (early termination)
vld_out  out  1  assembled vector valid
rdy_in  in  1  downstream ready
vec_out  out  W x VEC_LEN (signed unpacked)  assembled vector, registered

Behaviour:
- Reset: on rst at posedge clk, the following reset:
  - fill_buf, out_buf (drives vec_out) all 0; fill_idx=0; pend=0; out_valid=0.
  - Outputs after reset: vld_out=0, rdy_out=1, vec_out all 0.
  - Reset mid-fill discards partial data.
- Handshakes:
  - Accept when vld_in && rdy_out.
  - rdy_out = !pend. Combinational from state only; no dependence on vld_in.
  - Emit when vld_out && rdy_in. vld_out = out_valid.
- Accept:
  - chunk_in is written to fill_buf elements [fill_idx*CHUNK_LEN +: CHUNK_LEN].
  - Completion = last_in || fill_idx==NUM_CHUNKS-1.
  - If not completion, fill_idx increments.
- Completion:
  - Completed vector = fill_buf merged with the incoming chunk. Elements never written in this vector are 0 (zero-fill on early last_in).
  - The out slot is free when !out_valid || rdy_in.
  - If the out slot is free, the completed vector loads into out_buf on the same edge; out_valid=1; fill_buf cleared; fill_idx=0.
  - Otherwise fill_buf holds the completed vector; pend=1; fill_idx=0.
- pend handling: while pend && out slot free, fill_buf transfers to out_buf, out_valid=1, pend=0, fill_buf cleared. rdy_out returns 1 the following cycle.
- Drain with no transfer on the same edge: out_valid && rdy_in → out_valid=0. vec_out holds its stale value; it is don't-care while vld_out=0.
- Simultaneous drain + completion: the new vector replaces the old one, vld_out stays 1, no bubble.
- Latency: vld_out rises the cycle after the completing beat is accepted (1 cycle).
- Throughput: with rdy_in held at 1, 1 vector per NUM_CHUNKS cycles; NUM_CHUNKS=1 gives 1 vector/cycle.
- Ordering: vectors are emitted strictly in completion order. There is no drop and no duplication.
- last_in on beat 0: vector = chunk then zeros.
- Beats beyond NUM_CHUNKS cannot occur, because the counter forces completion.
- No arithmetic is performed. Elements are passed bit-exact; sign preserved.

Decomposition:
- Shared package gets:
  - elem_t (logic signed [W-1:0]).
  - The VEC_LEN/CHUNK_LEN defaults.
  - A CHUNKS_PER_VEC constant, reused by the fetch unit and the reduction pipeline.
- No sub-module is needed. The fill counter is a local always_ff. The output slot is a plain register, not a reusable skid buffer.

Test Plan:
(Params for all scenarios: VEC_LEN=8, CHUNK_LEN=2, W=16.)
1. Reset: assert rst for 2 cycles → vld_out=0, rdy_out=1, vec_out all 0.
2. Back-to-back beats {1,2},{3,4},{5,6},{7,8}, rdy_in=1, last_in only on the 4th beat → vld_out=1 for exactly 1 cycle, starting the cycle after the 4th accept. vec_out=1..8 (reduction downstream yields 36).
3. Early last: beats {-1,-2},{3,4} with last_in on the 2nd beat → vec_out={-1,-2,3,4,0,0,0,0}. The next vector starts at index 0.
4. Backpressure: rdy_in=0; send two full vectors A=1..8 and B=11..18.
   - A is in out_buf; B goes pending; rdy_out=0 the cycle after B's last accept.
   - A held 3rd-vector beat stays unaccepted.
   - Raise rdy_in → A, then B emitted on consecutive cycles.
   - rdy_out=1 the cycle after B transfers. The 3rd vector is intact.
5. Reset mid-fill after beats {9,9},{9,9}; then send 1..8 → vec_out=1..8, with no 9s visible.
6. Drain/complete collision: vector A valid with rdy_in=1 on the same edge that B's final beat is accepted → vld_out stays 1 with no bubble. Next cycle vec_out=B, and A is counted exactly once.
